// File: rtl/nn_layer_sequencer_if.sv
// Control/datapath bundle for one fully-connected layer sequencer.
// Latency: none (wires only).
// Backpressure: hold stalls read issue while the sequencer is in its MAC phase.
interface nn_layer_sequencer_if #(
  parameter int IN_AW  = 2,
  parameter int OUT_AW = 2,
  parameter int W_AW   = 4
);
  logic              start;
  logic              hold;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [IN_AW-1:0]  in_addr;
  logic [W_AW-1:0]   w_addr;
  logic              acc_clr;
  logic              acc_en;
  logic              out_we;
  logic [OUT_AW-1:0] out_addr;

  // Sequencer side: takes commands, drives the MAC and memory strobes.
  modport master (
    input  start, hold,
    output busy, done, rd_en, in_addr, w_addr, acc_clr, acc_en, out_we, out_addr
  );

  // Controller/datapath side.
  modport slave (
    output start, hold,
    input  busy, done, rd_en, in_addr, w_addr, acc_clr, acc_en, out_we, out_addr
  );
endinterface

// File: rtl/nn_layer_sequencer.sv
// Sequences one FC layer: per neuron clear acc, issue N_IN reads, drain, write.
// Latency: N_OUT*(N_IN+3) cycles from the start edge to done (no stalls); all outputs registered.
// Backpressure: hold sampled in MAC suppresses the next read issue and freezes i/w/state.
module nn_layer_sequencer #(
  parameter int N_IN   = 4,
  parameter int N_OUT  = 4,
  parameter int IN_AW  = 2,
  parameter int OUT_AW = 2,
  parameter int W_AW   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  nn_layer_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_MAC, S_DRAIN, S_WRITE, S_DONE
  } state_t;

  localparam logic [IN_AW-1:0]  I_LAST = IN_AW'(N_IN - 1);
  localparam logic [OUT_AW-1:0] J_LAST = OUT_AW'(N_OUT - 1);

  state_t state_q, state_d;

  // i/w hold the index of the read being issued (or pending, when stalled).
  logic [IN_AW-1:0]  i_q, i_d;
  logic [OUT_AW-1:0] j_q, j_d;
  logic [W_AW-1:0]   w_q, w_d;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_en_q, rd_en_d;
  logic [IN_AW-1:0]  in_addr_q, in_addr_d;
  logic [W_AW-1:0]   w_addr_q, w_addr_d;
  logic              acc_clr_q, acc_clr_d;
  logic              acc_en_q, acc_en_d;
  logic              out_we_q, out_we_d;
  logic [OUT_AW-1:0] out_addr_q, out_addr_d;

  // Next state and next registered outputs; outputs are decoded one cycle
  // ahead so each output cycle lines up with the state it belongs to.
  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    w_d        = w_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rd_en_d    = 1'b0;
    in_addr_d  = in_addr_q;
    w_addr_d   = w_addr_q;
    acc_clr_d  = 1'b0;
    acc_en_d   = rd_en_q;
    out_we_d   = 1'b0;
    out_addr_d = out_addr_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d   = S_CLEAR;
          i_d       = '0;
          j_d       = '0;
          w_d       = '0;
          busy_d    = 1'b1;
          acc_clr_d = 1'b1;
        end
      end
      S_CLEAR: begin
        // First read of a neuron is always issued: hold only matters in MAC.
        state_d   = S_MAC;
        rd_en_d   = 1'b1;
        in_addr_d = i_q;
        w_addr_d  = w_q;
      end
      S_MAC: begin
        if (rd_en_q) begin
          // The read of index i went out this cycle.
          w_d = w_q + W_AW'(1);
          if (i_q == I_LAST) begin
            state_d = S_DRAIN;
          end else begin
            i_d = i_q + IN_AW'(1);
            if (!bus.hold) begin
              rd_en_d   = 1'b1;
              in_addr_d = i_d;
              w_addr_d  = w_d;
            end
          end
        end else if (!bus.hold) begin
          // Stalled cycle: re-attempt the pending index.
          rd_en_d   = 1'b1;
          in_addr_d = i_q;
          w_addr_d  = w_q;
        end
      end
      S_DRAIN: begin
        // Lets acc_en cover the final read before the result is written.
        state_d    = S_WRITE;
        out_we_d   = 1'b1;
        out_addr_d = j_q;
      end
      S_WRITE: begin
        if (j_q == J_LAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d   = S_CLEAR;
          j_d       = j_q + OUT_AW'(1);
          i_d       = '0;
          acc_clr_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, counters and output registers; reset aborts any layer in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      i_q        <= '0;
      j_q        <= '0;
      w_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      in_addr_q  <= '0;
      w_addr_q   <= '0;
      acc_clr_q  <= 1'b0;
      acc_en_q   <= 1'b0;
      out_we_q   <= 1'b0;
      out_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      w_q        <= w_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_en_q    <= rd_en_d;
      in_addr_q  <= in_addr_d;
      w_addr_q   <= w_addr_d;
      acc_clr_q  <= acc_clr_d;
      acc_en_q   <= acc_en_d;
      out_we_q   <= out_we_d;
      out_addr_q <= out_addr_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.rd_en    = rd_en_q;
  assign bus.in_addr  = in_addr_q;
  assign bus.w_addr   = w_addr_q;
  assign bus.acc_clr  = acc_clr_q;
  assign bus.acc_en   = acc_en_q;
  assign bus.out_we   = out_we_q;
  assign bus.out_addr = out_addr_q;

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Directed bench for nn_layer_sequencer: 4x4 layer scenarios plus a 1x3 instance.
// Latency: checks done edge, read/write ordering and counts per layer.
// Backpressure: exercises hold stalls inside and at the edge of the MAC phase.
module tb_nn_layer_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nn_layer_sequencer_if #(.IN_AW(2), .OUT_AW(2), .W_AW(4)) ifa ();
  nn_layer_sequencer_if #(.IN_AW(1), .OUT_AW(2), .W_AW(2)) ifb ();

  nn_layer_sequencer #(.N_IN(4), .N_OUT(4), .IN_AW(2), .OUT_AW(2), .W_AW(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.master)
  );

  nn_layer_sequencer #(.N_IN(1), .N_OUT(3), .IN_AW(1), .OUT_AW(2), .W_AW(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.master)
  );

  int   n_chk  = 0;
  int   n_fail = 0;
  logic prev_rd_a = 1'b0;
  logic prev_rd_b = 1'b0;
  logic rst_seen  = 1'b1;

  typedef struct {
    int hold_at;   // hold raised right after this many reads were observed
    int hold_len;  // cycles hold stays high
    int exp_done;  // edges from the start-sampling edge to done
    int exp_rd;
    int exp_we;
    int exp_clr;
    int exp_acc;
  } scen_t;

  scen_t tbl [4];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock; sample 1 time unit after the edge and run the per-cycle invariants.
  task automatic step();
    @(posedge clk);
    #1;
    if (!rst && !rst_seen) begin
      chk("acc_en_a_follows_rd", int'(ifa.acc_en), int'(prev_rd_a));
      chk("rd_excl_a", int'(ifa.rd_en & (ifa.acc_clr | ifa.out_we)), 0);
      chk("acc_en_b_follows_rd", int'(ifb.acc_en), int'(prev_rd_b));
      chk("rd_excl_b", int'(ifb.rd_en & (ifb.acc_clr | ifb.out_we)), 0);
    end
    prev_rd_a = ifa.rd_en;
    prev_rd_b = ifb.rd_en;
    rst_seen  = rst;
  endtask

  // Runs one 4x4 layer on dut_a, checking addresses as reads/writes appear.
  task automatic run_layer(input int hold_at, input int hold_len,
                           output int done_edge, output int rd, output int we,
                           output int clr, output int acc);
    int hold_left;
    rd = 0; we = 0; clr = 0; acc = 0; done_edge = -1; hold_left = 0;
    ifa.start = 1'b1;
    step();
    chk("busy_on_start", int'(ifa.busy), 1);
    if (ifa.acc_clr) clr++;
    ifa.start = 1'b0;
    for (int e = 1; e <= 200 && done_edge < 0; e++) begin
      step();
      if (hold_left > 0) begin
        hold_left--;
        if (hold_left == 0) ifa.hold = 1'b0;
      end
      if (ifa.rd_en) begin
        chk("in_addr", int'(ifa.in_addr), rd % 4);
        chk("w_addr", int'(ifa.w_addr), rd);
        rd++;
        if (rd == hold_at && hold_len > 0) begin
          ifa.hold  = 1'b1;
          hold_left = hold_len;
        end
      end
      if (ifa.out_we) begin
        chk("out_addr", int'(ifa.out_addr), we);
        we++;
      end
      if (ifa.acc_clr) clr++;
      if (ifa.acc_en) acc++;
      if (ifa.done) done_edge = e;
    end
    ifa.hold = 1'b0;
    if (done_edge < 0) chk("done_timeout", 0, 1);
    step();
    chk("busy_after_done", int'(ifa.busy), 0);
    chk("done_one_cycle", int'(ifa.done), 0);
  endtask

  initial begin
    int de, rd, we, clr, acc, rdb, web, cnt;

    tbl[0] = '{hold_at: -1, hold_len: 0, exp_done: 28, exp_rd: 16, exp_we: 4, exp_clr: 4, exp_acc: 16};
    tbl[1] = '{hold_at:  6, hold_len: 3, exp_done: 31, exp_rd: 16, exp_we: 4, exp_clr: 4, exp_acc: 16};
    tbl[2] = '{hold_at: 13, hold_len: 1, exp_done: 29, exp_rd: 16, exp_we: 4, exp_clr: 4, exp_acc: 16};
    tbl[3] = '{hold_at:  4, hold_len: 2, exp_done: 28, exp_rd: 16, exp_we: 4, exp_clr: 4, exp_acc: 16};

    ifa.start = 1'b0; ifa.hold = 1'b0;
    ifb.start = 1'b0; ifb.hold = 1'b0;
    rst = 1'b1;
    step();
    step();
    chk("rst_busy",     int'(ifa.busy), 0);
    chk("rst_done",     int'(ifa.done), 0);
    chk("rst_rd_en",    int'(ifa.rd_en), 0);
    chk("rst_in_addr",  int'(ifa.in_addr), 0);
    chk("rst_w_addr",   int'(ifa.w_addr), 0);
    chk("rst_acc_clr",  int'(ifa.acc_clr), 0);
    chk("rst_acc_en",   int'(ifa.acc_en), 0);
    chk("rst_out_we",   int'(ifa.out_we), 0);
    chk("rst_out_addr", int'(ifa.out_addr), 0);
    chk("rst_busy_b",   int'(ifb.busy), 0);
    rst = 1'b0;
    step();
    step();

    // Table-driven layers on the 4x4 instance.
    for (int k = 0; k < 4; k++) begin
      run_layer(tbl[k].hold_at, tbl[k].hold_len, de, rd, we, clr, acc);
      chk("tbl_done_edge", de,  tbl[k].exp_done);
      chk("tbl_rd_count",  rd,  tbl[k].exp_rd);
      chk("tbl_we_count",  we,  tbl[k].exp_we);
      chk("tbl_clr_count", clr, tbl[k].exp_clr);
      chk("tbl_acc_count", acc, tbl[k].exp_acc);
      step();
    end

    // start held high: one layer, then a fresh layer only because start is still high in IDLE.
    ifa.start = 1'b1;
    step();
    rd = 0; de = -1;
    for (int e = 1; e <= 200 && de < 0; e++) begin
      step();
      if (ifa.rd_en) rd++;
      if (ifa.done) de = e;
    end
    chk("held_done_edge", de, 28);
    chk("held_rd_count",  rd, 16);
    step();
    chk("held_busy_drop", int'(ifa.busy), 0);
    step();
    chk("held_restart_busy", int'(ifa.busy), 1);
    chk("held_restart_clr",  int'(ifa.acc_clr), 1);
    ifa.start = 1'b0;
    rd = 0; de = -1;
    for (int e = 1; e <= 200 && de < 0; e++) begin
      step();
      if (ifa.rd_en) begin
        chk("held2_w_addr", int'(ifa.w_addr), rd);
        rd++;
      end
      if (ifa.done) de = e;
    end
    chk("held2_done_edge", de, 28);
    chk("held2_rd_count",  rd, 16);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("held2_idle_busy", int'(ifa.busy), 0);
    end

    // Reset during MAC of neuron 2.
    ifa.start = 1'b1;
    step();
    ifa.start = 1'b0;
    cnt = 0;
    for (int e = 0; e < 100 && cnt < 9; e++) begin
      step();
      if (ifa.rd_en) cnt++;
    end
    chk("rst_mid_reached", cnt, 9);
    rst = 1'b1;
    step();
    chk("rstmid_busy",     int'(ifa.busy), 0);
    chk("rstmid_rd_en",    int'(ifa.rd_en), 0);
    chk("rstmid_acc_en",   int'(ifa.acc_en), 0);
    chk("rstmid_acc_clr",  int'(ifa.acc_clr), 0);
    chk("rstmid_out_we",   int'(ifa.out_we), 0);
    chk("rstmid_done",     int'(ifa.done), 0);
    chk("rstmid_in_addr",  int'(ifa.in_addr), 0);
    chk("rstmid_w_addr",   int'(ifa.w_addr), 0);
    chk("rstmid_out_addr", int'(ifa.out_addr), 0);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("post_rst_quiet", int'(ifa.rd_en | ifa.out_we | ifa.done | ifa.busy), 0);
    end
    run_layer(-1, 0, de, rd, we, clr, acc);
    chk("post_rst_done_edge", de, 28);
    chk("post_rst_rd_count",  rd, 16);
    chk("post_rst_we_count",  we, 4);

    // Degenerate N_IN=1 on the 1x3 instance.
    step();
    ifb.start = 1'b1;
    step();
    chk("b_busy_on_start", int'(ifb.busy), 1);
    ifb.start = 1'b0;
    rdb = 0; web = 0; de = -1;
    for (int e = 1; e <= 60 && de < 0; e++) begin
      step();
      if (ifb.rd_en) begin
        chk("b_w_addr",  int'(ifb.w_addr), rdb);
        chk("b_in_addr", int'(ifb.in_addr), 0);
        rdb++;
      end
      if (ifb.out_we) begin
        chk("b_out_addr", int'(ifb.out_addr), web);
        web++;
      end
      if (ifb.done) de = e;
    end
    chk("b_done_edge", de, 12);
    chk("b_rd_count",  rdb, 3);
    chk("b_we_count",  web, 3);
    step();
    chk("b_busy_after_done", int'(ifb.busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
